udp_shreg_arbiter: RTL and testbench
====================================

# udp_shreg_arbiter

Frame-level round-robin arbiter that shares one fixed-latency UDP shift register between two streaming requesters (s0, s1). It grants whole frames, feeds the granted stream into the shift register, and carries a matching valid/last/source tag pipeline so the delayed data leaves on m_* with correct framing. It also enforces a maximum frame length. It sits between the UDP header/payload sources and the fixed-latency delay line in the TX path; the shift register is instantiated by the parent and connected through the sr_* ports.

## Interface
- DATA_WIDTH, 8: beat width; must match the shift register.
- LATENCY, 8: shift register depth in cycles; 1..1024; must equal its FIXED_DEPTH.
- MAX_BEATS, 1500: maximum beats per frame; 2..2^CNT_WIDTH-1.
- CNT_WIDTH, 11: width of the beat counter.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- s0_data / s1_data  in  DATA_WIDTH  requester beat data.
- s0_valid / s1_valid  in  1  beat valid.
- s0_last / s1_last  in  1  final beat of the frame.
- s0_ready / s1_ready  out  1  beat accepted when valid&ready at an edge.
- sr_din  out  DATA_WIDTH  to the shift register input.
- sr_dout  in  DATA_WIDTH  from the shift register output.
- m_data  out  DATA_WIDTH  delayed data (= sr_dout).
- m_valid  out  1  delayed beat valid; no backpressure.
- m_last  out  1  delayed frame end (true or forced).
- m_src  out  1  source of the delayed beat (0 = s0, 1 = s1).
- busy  out  1  state ≠ IDLE.
- trunc_err  out  1  one-cycle pulse when a frame is truncated.

## Operation
- States: IDLE, XFER, DROP. Registers: owner (1 bit), prio (1 bit), beat_cnt (CNT_WIDTH).
- IDLE:
  - s*_ready = 0.
  - If only one requester is valid, owner ← that requester. If both are valid, owner ← prio.
  - If any requester is valid, go to XFER with beat_cnt ← 0. Otherwise stay in IDLE.
- XFER:
  - ready[owner] = 1; ready[other] = 0.
  - On each accepted beat: beat_cnt += 1 and the tag {valid=1, last, src=owner} is pushed.
  - Accepted beat with last=1: go to IDLE; prio ← ~owner.
  - Accepted beat with last=0 and beat_cnt+1 == MAX_BEATS: the pushed tag has last forced to 1; trunc_err pulses on the next cycle; go to DROP.
- DROP:
  - ready[owner] = 1. Accepted beats are discarded: a {0,0,0} tag is pushed and no counting occurs.
  - Accepted beat with last=1: go to IDLE; prio ← ~owner.
- sr_din = s[owner]_data when a beat is accepted in XFER, otherwise 0.
- The tag pipeline is LATENCY registers of {valid, last, src} and shifts every cycle. Its input is {0,0,0} whenever no beat is accepted in XFER.
- m_valid / m_last / m_src = tag pipeline output stage. m_data = sr_dout passed through combinationally.
- The non-owner requester is never dropped. It is served at the next IDLE.
- Invalid beats (valid=0 while ready=1) are bubbles: nothing is pushed and nothing is counted.

## Timing
- Reset values:
  - state = IDLE, owner = 0, prio = 0, beat_cnt = 0, all tag stages = 0.
  - s*_ready = 0, m_valid = 0, m_last = 0, m_src = 0, busy = 0, trunc_err = 0, sr_din = 0.
- Arbitration bubble: a request seen in IDLE at edge k is granted ready from cycle k+1.
  - Back-to-back frames therefore have exactly one idle cycle between them.
- Latency: a beat accepted at edge k is sampled on m_* at edge k+LATENCY. Data and tag paths are exactly aligned.
- A frame of N ≤ MAX_BEATS beats with no bubbles occupies N consecutive m_valid cycles.
- trunc_err is asserted for one cycle, the cycle after the truncating beat's edge.
- Reset mid-frame:
  - All state and tags clear at that edge; m_valid = 0 from the next cycle for ≥ LATENCY cycles unless new beats are accepted.
  - The partial frame is lost with no m_last.
  - Stale shift register contents are masked by valid = 0.
- Simultaneous last-beat acceptance and a request from the other side: the other side is granted from IDLE on the following edge. It is not granted in the same cycle.

## Structure
- Package udp_shreg_pkg holds:
  - state enum {IDLE, XFER, DROP};
  - the tag struct {valid, last, src};
  - default constants for DATA_WIDTH, LATENCY, MAX_BEATS.
- Sub-module udp_shreg_tag_pipe: a LATENCY-deep tag delay line with synchronous reset.
- The FSM, counter and mux live in the top module. The shift register itself stays in the parent.

## Test plan
- Single frame, LATENCY=8: s0 sends 4 beats 0x11..0x14 starting at edge 10 (granted at 11).
  - m_valid is high at edges 19–22; m_data = 0x11..0x14; m_last only at 22; m_src = 0.
- Contention: s0 and s1 both valid in IDLE after reset.
  - s0 frame goes first, one idle cycle follows, then the s1 frame with m_src = 1.
  - The next simultaneous request is granted to s0 again (alternation).
- Truncation, MAX_BEATS=4: s1 sends 6 beats.
  - m shows 4 beats with m_last forced on beat 4.
  - trunc_err pulses once; beats 5–6 are accepted and absent from m_*.
  - State returns to IDLE after beat 6.
- Bubbles: s0_valid toggles 1,0,1,0 over a 3-beat frame.
  - m_valid reproduces the same gap pattern delayed by LATENCY; beat_cnt counts 3.
- Reset mid-frame: assert rst after 2 of 5 accepted beats.
  - ready = 0 and busy = 0 on the next cycle.
  - No m_valid appears for the discarded beats; a new s1 frame then completes normally.

Source files
------------

// File: rtl/udp_shreg_pkg.sv
//==============================================================================
// Package : udp_shreg_pkg
// Desc    : Shared types and default constants for the UDP shift-register arbiter.
// Rev     : 1.0 - initial release
//==============================================================================
`default_nettype none

package udp_shreg_pkg;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_LATENCY    = 8;
    localparam int c_DEF_MAX_BEATS  = 1500;
    localparam int c_DEF_CNT_WIDTH  = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
        logic src;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/udp_shreg_arbiter_if.sv
//==============================================================================
// Interface : udp_shreg_arbiter_if
// Desc      : Requester streams, shift-register link and delayed output bundle.
// Rev       : 1.0 - initial release
//==============================================================================
`default_nettype none

interface udp_shreg_arbiter_if
    import udp_shreg_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] s0_data;
    logic                  s0_valid;
    logic                  s0_last;
    logic                  s0_ready;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  s1_last;
    logic                  s1_ready;
    logic [DATA_WIDTH-1:0] sr_din;
    logic [DATA_WIDTH-1:0] sr_dout;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_src;

    // Arbiter side
    modport slave (
        input  s0_data, s0_valid, s0_last,
        input  s1_data, s1_valid, s1_last,
        input  sr_dout,
        output s0_ready, s1_ready, sr_din,
        output m_data, m_valid, m_last, m_src
    );

    // Requester / shift-register / sink side
    modport master (
        output s0_data, s0_valid, s0_last,
        output s1_data, s1_valid, s1_last,
        output sr_dout,
        input  s0_ready, s1_ready, sr_din,
        input  m_data, m_valid, m_last, m_src
    );

endinterface

`default_nettype wire

// File: rtl/udp_shreg_tag_pipe.sv
//==============================================================================
// Module : udp_shreg_tag_pipe
// Desc   : LATENCY-deep {valid,last,src} delay line matching the data shift register.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module udp_shreg_tag_pipe
    import udp_shreg_pkg::*;
#(
    parameter int LATENCY = c_DEF_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_stage [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/udp_shreg_arbiter.sv
//==============================================================================
// Module : udp_shreg_arbiter
// Desc   : Frame-level round-robin arbiter feeding a shared fixed-latency shift register.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module udp_shreg_arbiter
    import udp_shreg_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int LATENCY    = c_DEF_LATENCY,
    parameter int MAX_BEATS  = c_DEF_MAX_BEATS,
    parameter int CNT_WIDTH  = c_DEF_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    udp_shreg_arbiter_if.slave bus,
    output logic               busy,
    output logic               trunc_err
);

    localparam logic [CNT_WIDTH-1:0] c_MAX_BEATS = CNT_WIDTH'(MAX_BEATS);

    state_t                r_state, w_state_nxt;
    logic                  r_owner, w_owner_nxt;
    logic                  r_prio,  w_prio_nxt;
    logic [CNT_WIDTH-1:0]  r_beat_cnt, w_cnt_nxt;
    logic                  r_trunc, w_trunc_nxt;

    logic                  w_own_valid;
    logic                  w_own_last;
    logic [DATA_WIDTH-1:0] w_own_data;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_at_max;
    logic                  w_ready0, w_ready1;
    logic [DATA_WIDTH-1:0] w_sr_din;
    tag_t                  w_tag_in, w_tag_out;

    assign w_own_valid = r_owner ? bus.s1_valid : bus.s0_valid;
    assign w_own_last  = r_owner ? bus.s1_last  : bus.s0_last;
    assign w_own_data  = r_owner ? bus.s1_data  : bus.s0_data;
    assign w_cnt_inc   = r_beat_cnt + 1'b1;
    assign w_at_max    = (w_cnt_inc == c_MAX_BEATS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_prio     <= 1'b0;
            r_beat_cnt <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_prio     <= w_prio_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_trunc    <= w_trunc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_prio_nxt  = r_prio;
        w_cnt_nxt   = r_beat_cnt;
        w_trunc_nxt = 1'b0;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_sr_din    = '0;
        w_tag_in    = '0;
        case (r_state)
            IDLE: begin
                if (bus.s0_valid || bus.s1_valid) begin
                    w_owner_nxt = (bus.s0_valid && bus.s1_valid) ? r_prio : bus.s1_valid;
                    w_state_nxt = XFER;
                    w_cnt_nxt   = '0;
                end
            end
            XFER: begin
                w_ready0 = ~r_owner;
                w_ready1 = r_owner;
                if (w_own_valid) begin
                    w_cnt_nxt      = w_cnt_inc;
                    w_sr_din       = w_own_data;
                    w_tag_in.valid = 1'b1;
                    // A frame hitting the beat limit is closed early with a forced last
                    w_tag_in.last  = w_own_last | w_at_max;
                    w_tag_in.src   = r_owner;
                    if (w_own_last) begin
                        w_state_nxt = IDLE;
                        w_prio_nxt  = ~r_owner;
                    end else if (w_at_max) begin
                        w_state_nxt = DROP;
                        w_trunc_nxt = 1'b1;
                    end
                end
            end
            DROP: begin
                w_ready0 = ~r_owner;
                w_ready1 = r_owner;
                if (w_own_valid && w_own_last) begin
                    w_state_nxt = IDLE;
                    w_prio_nxt  = ~r_owner;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    udp_shreg_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign bus.s0_ready = w_ready0;
    assign bus.s1_ready = w_ready1;
    assign bus.sr_din   = w_sr_din;
    assign bus.m_data   = bus.sr_dout;
    assign bus.m_valid  = w_tag_out.valid;
    assign bus.m_last   = w_tag_out.last;
    assign bus.m_src    = w_tag_out.src;
    assign busy         = (r_state != IDLE);
    assign trunc_err    = r_trunc;

endmodule

`default_nettype wire

// File: tb/tb_udp_shreg_arbiter.sv
//==============================================================================
// Module : tb_udp_shreg_arbiter
// Desc   : Directed self-checking bench; LATENCY=8, MAX_BEATS=4, shift register modelled here.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_udp_shreg_arbiter;

    localparam int c_LAT = 8;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       s;
        int         c;
    } mbeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic trunc_err;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mbeat_t mon_q[$];
    mbeat_t mon_b;
    int     trunc_q[$];
    logic [7:0] sr_pipe [c_LAT];

    udp_shreg_arbiter_if #(.DATA_WIDTH(8)) bus ();

    udp_shreg_arbiter #(
        .DATA_WIDTH (8),
        .LATENCY    (c_LAT),
        .MAX_BEATS  (4),
        .CNT_WIDTH  (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .trunc_err (trunc_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Parent-owned shift register model
    always @(posedge clk) begin
        sr_pipe[0] <= bus.sr_din;
        for (int i = 1; i < c_LAT; i++) sr_pipe[i] <= sr_pipe[i-1];
    end
    assign bus.sr_dout = sr_pipe[c_LAT-1];

    always @(negedge clk) begin
        if (bus.m_valid === 1'b1) begin
            mon_b.d = bus.m_data;
            mon_b.l = bus.m_last;
            mon_b.s = bus.m_src;
            mon_b.c = cyc;
            mon_q.push_back(mon_b);
        end
        if (trunc_err === 1'b1) trunc_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input bit src, input logic [7:0] d, input bit last);
        int t = 0;
        if (src) begin
            bus.s1_data = d; bus.s1_valid = 1'b1; bus.s1_last = last;
        end else begin
            bus.s0_data = d; bus.s0_valid = 1'b1; bus.s0_last = last;
        end
        @(negedge clk);
        while ((src ? bus.s1_ready : bus.s0_ready) !== 1'b1) begin
            t++;
            if (t > 100) begin
                checks++;
                failures++;
                $display("FAIL grant_timeout: src=%0d ready=0 after 100 cycles, required 1", src);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (src) begin
            bus.s1_data = '0; bus.s1_valid = 1'b0; bus.s1_last = 1'b0;
        end else begin
            bus.s0_data = '0; bus.s0_valid = 1'b0; bus.s0_last = 1'b0;
        end
    endtask

    task automatic send_frame(input bit src, input int n, input logic [7:0] base, input bit gap);
        for (int i = 0; i < n; i++) begin
            send_beat(src, 8'(base + i), (i == n - 1));
            if (gap && (i != n - 1)) tick(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s0_data = '0; bus.s0_valid = 1'b0; bus.s0_last = 1'b0;
        bus.s1_data = '0; bus.s1_valid = 1'b0; bus.s1_last = 1'b0;
        tick(3);
        checks++; if (bus.s0_ready !== 1'b0) begin failures++; $display("FAIL reset_s0_ready: got %b, required 0", bus.s0_ready); end
        checks++; if (bus.s1_ready !== 1'b0) begin failures++; $display("FAIL reset_s1_ready: got %b, required 0", bus.s1_ready); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid); end
        checks++; if (bus.m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last: got %b, required 0", bus.m_last); end
        checks++; if (bus.m_src !== 1'b0) begin failures++; $display("FAIL reset_m_src: got %b, required 0", bus.m_src); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (trunc_err !== 1'b0) begin failures++; $display("FAIL reset_trunc_err: got %b, required 0", trunc_err); end
        checks++; if (bus.sr_din !== 8'h00) begin failures++; $display("FAIL reset_sr_din: got %h, required 00", bus.sr_din); end
        rst = 1'b0;
        tick(1);
    endtask

    // Request raised after edge c0: grant at c0+1, beats accepted from c0+2, out at c0+9
    task automatic test_single_frame();
        int c0;
        mon_q.delete(); trunc_q.delete();
        c0 = cyc;
        send_frame(1'b0, 4, 8'h11, 1'b0);
        tick(c_LAT + 4);
        checks++; if (mon_q.size() != 4) begin failures++; $display("FAIL single_count: got %0d beats, required 4", mon_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= mon_q.size()) begin
                failures++; $display("FAIL single_beat%0d: missing, required d=%h", i, 8'(8'h11 + i));
            end else if (mon_q[i].d !== 8'(8'h11 + i) || mon_q[i].l !== (i == 3) || mon_q[i].s !== 1'b0 || mon_q[i].c != c0 + 9 + i) begin
                failures++;
                $display("FAIL single_beat%0d: got d=%h l=%b s=%b cyc=%0d, required d=%h l=%b s=0 cyc=%0d",
                         i, mon_q[i].d, mon_q[i].l, mon_q[i].s, mon_q[i].c, 8'(8'h11 + i), (i == 3), c0 + 9 + i);
            end
        end
        checks++; if (trunc_q.size() != 0) begin failures++; $display("FAIL single_no_trunc: got %0d pulses, required 0", trunc_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end: got %b, required 0", busy); end
    endtask

    task automatic test_contention();
        int c0;
        logic [7:0] ed [5] = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2};
        logic       el [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       es [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int         ec [5] = '{9, 10, 12, 13, 14};
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mon_q.delete();
        c0 = cyc;
        fork
            send_frame(1'b0, 2, 8'hA0, 1'b0);
            send_frame(1'b1, 3, 8'hB0, 1'b0);
        join
        tick(c_LAT + 4);
        checks++; if (mon_q.size() != 5) begin failures++; $display("FAIL contend_count: got %0d beats, required 5", mon_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= mon_q.size()) begin
                failures++; $display("FAIL contend_beat%0d: missing, required d=%h", i, ed[i]);
            end else if (mon_q[i].d !== ed[i] || mon_q[i].l !== el[i] || mon_q[i].s !== es[i] || mon_q[i].c != c0 + ec[i]) begin
                failures++;
                $display("FAIL contend_beat%0d: got d=%h l=%b s=%b cyc=%0d, required d=%h l=%b s=%b cyc=%0d",
                         i, mon_q[i].d, mon_q[i].l, mon_q[i].s, mon_q[i].c, ed[i], el[i], es[i], c0 + ec[i]);
            end
        end
        // s1 finished last, so the next tie goes back to s0
        mon_q.delete();
        c0 = cyc;
        fork
            send_frame(1'b0, 1, 8'hC0, 1'b0);
            send_frame(1'b1, 1, 8'hD0, 1'b0);
        join
        tick(c_LAT + 4);
        checks++;
        if (mon_q.size() < 1 || mon_q[0].s !== 1'b0 || mon_q[0].d !== 8'hC0 || mon_q[0].c != c0 + 9) begin
            failures++; $display("FAIL alternate_first: got n=%0d, required d=C0 s=0 cyc=%0d", mon_q.size(), c0 + 9);
        end
        checks++;
        if (mon_q.size() < 2 || mon_q[1].s !== 1'b1 || mon_q[1].d !== 8'hD0 || mon_q[1].c != c0 + 11) begin
            failures++; $display("FAIL alternate_second: got n=%0d, required d=D0 s=1 cyc=%0d", mon_q.size(), c0 + 11);
        end
    endtask

    // Beats accepted c0+2..c0+7; beat 4 (c0+5) truncates, beats 5-6 dropped
    task automatic test_truncation();
        int c0;
        int cdone;
        mon_q.delete(); trunc_q.delete();
        c0 = cyc;
        send_frame(1'b1, 6, 8'h31, 1'b0);
        cdone = cyc;
        checks++; if (cdone != c0 + 7) begin failures++; $display("FAIL trunc_drop_accept: last beat at cyc %0d, required %0d", cdone, c0 + 7); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL trunc_idle_after: busy=%b, required 0", busy); end
        tick(c_LAT + 4);
        checks++; if (mon_q.size() != 4) begin failures++; $display("FAIL trunc_count: got %0d beats, required 4", mon_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= mon_q.size()) begin
                failures++; $display("FAIL trunc_beat%0d: missing, required d=%h", i, 8'(8'h31 + i));
            end else if (mon_q[i].d !== 8'(8'h31 + i) || mon_q[i].l !== (i == 3) || mon_q[i].s !== 1'b1 || mon_q[i].c != c0 + 9 + i) begin
                failures++;
                $display("FAIL trunc_beat%0d: got d=%h l=%b s=%b cyc=%0d, required d=%h l=%b s=1 cyc=%0d",
                         i, mon_q[i].d, mon_q[i].l, mon_q[i].s, mon_q[i].c, 8'(8'h31 + i), (i == 3), c0 + 9 + i);
            end
        end
        checks++;
        if (trunc_q.size() != 1 || trunc_q[0] != c0 + 5) begin
            failures++; $display("FAIL trunc_pulse: got %0d pulses, required exactly 1 at cyc %0d", trunc_q.size(), c0 + 5);
        end
    endtask

    task automatic test_bubbles();
        int c0;
        int ec [3] = '{9, 11, 13};
        mon_q.delete(); trunc_q.delete();
        c0 = cyc;
        send_frame(1'b0, 3, 8'h51, 1'b1);
        checks++; if (dut.r_beat_cnt !== 11'd3) begin failures++; $display("FAIL bubble_beat_cnt: got %0d, required 3", dut.r_beat_cnt); end
        tick(c_LAT + 4);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= mon_q.size()) begin
                failures++; $display("FAIL bubble_beat%0d: missing, required d=%h", i, 8'(8'h51 + i));
            end else if (mon_q[i].d !== 8'(8'h51 + i) || mon_q[i].l !== (i == 2) || mon_q[i].s !== 1'b0 || mon_q[i].c != c0 + ec[i]) begin
                failures++;
                $display("FAIL bubble_beat%0d: got d=%h l=%b s=%b cyc=%0d, required d=%h l=%b s=0 cyc=%0d",
                         i, mon_q[i].d, mon_q[i].l, mon_q[i].s, mon_q[i].c, 8'(8'h51 + i), (i == 2), c0 + ec[i]);
            end
        end
        checks++; if (mon_q.size() != 3 || trunc_q.size() != 0) begin failures++; $display("FAIL bubble_totals: got %0d beats %0d pulses, required 3 beats 0 pulses", mon_q.size(), trunc_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int c1;
        mon_q.delete(); trunc_q.delete();
        send_beat(1'b0, 8'h61, 1'b0);
        send_beat(1'b0, 8'h62, 1'b0);
        bus.s0_data = 8'h63; bus.s0_valid = 1'b1; bus.s0_last = 1'b0;
        rst = 1'b1;
        tick(1);
        checks++; if (bus.s0_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready: got %b, required 0", bus.s0_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        rst = 1'b0;
        bus.s0_data = '0; bus.s0_valid = 1'b0;
        tick(c_LAT + 4);
        checks++; if (mon_q.size() != 0) begin failures++; $display("FAIL rstmid_masked: got %0d beats, required 0", mon_q.size()); end
        mon_q.delete();
        c1 = cyc;
        send_frame(1'b1, 2, 8'h71, 1'b0);
        tick(c_LAT + 4);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= mon_q.size()) begin
                failures++; $display("FAIL rstmid_new%0d: missing, required d=%h", i, 8'(8'h71 + i));
            end else if (mon_q[i].d !== 8'(8'h71 + i) || mon_q[i].l !== (i == 1) || mon_q[i].s !== 1'b1 || mon_q[i].c != c1 + 9 + i) begin
                failures++;
                $display("FAIL rstmid_new%0d: got d=%h l=%b s=%b cyc=%0d, required d=%h l=%b s=1 cyc=%0d",
                         i, mon_q[i].d, mon_q[i].l, mon_q[i].s, mon_q[i].c, 8'(8'h71 + i), (i == 1), c1 + 9 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_truncation();
        test_bubbles();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
